yolo_upsamp_seq: RTL and testbench

- Run-level sequencer for the yolo_upsamp_top HLS kernel.
- Per run it latches a layer configuration and issues ap_start with the ap_ready handshake. It then counts inStream and outStream beats, checks them against the expected 2x-upsample volumes, and detects stalls with a watchdog.
- Sits between the PS-side control registers and the kernel. It observes the AXI-Stream handshakes and does not drive them.

---
 rtl/yolo_upsamp_pkg.sv | 23 ++
 rtl/yolo_upsamp_wdog.sv | 43 ++++
 rtl/yolo_upsamp_seq.sv | 154 +++++++++++++++
 tb/tb_yolo_upsamp_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_upsamp_pkg.sv
// State and error-cause encodings shared by the yolo_upsamp_top run sequencer.
// Latency/backpressure: none (declarations only).
package yolo_upsamp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        START,
        RUN,
        DONE,
        ERR
    } state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_CFG      = 3'd1;
    localparam logic [2:0] ERR_STARVE   = 3'd2;
    localparam logic [2:0] ERR_BKPR     = 3'd3;
    localparam logic [2:0] ERR_OVERRUN  = 3'd4;
    localparam logic [2:0] ERR_MISMATCH = 3'd5;
    localparam logic [2:0] ERR_STALL    = 3'd6;
    localparam logic [2:0] ERR_ABORT    = 3'd7;

endpackage

// File: rtl/yolo_upsamp_wdog.sv
// Stream stall watchdog: counts beat-free cycles and classifies the stall cause.
// Latency: expired is combinational on the TIMEOUT-th quiet cycle; backpressure: none, observe-only.
module yolo_upsamp_wdog
    import yolo_upsamp_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       beat,
    input  logic       in_tvalid,
    input  logic       in_tready,
    input  logic       out_tvalid,
    input  logic       out_tready,
    output logic       expired,
    output logic [2:0] cause
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en || beat) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    // Fires on the quiet cycle that would bring the count up to TIMEOUT.
    assign expired = en && !beat && (cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        cause = ERR_STALL;
        if (in_tready && !in_tvalid) begin
            cause = ERR_STARVE;
        end else if (out_tvalid && !out_tready) begin
            cause = ERR_BKPR;
        end
    end

endmodule

// File: rtl/yolo_upsamp_seq.sv
// Run sequencer for yolo_upsamp_top: ap_start handshake, beat accounting vs 2x-upsample volume, stall watchdog.
// Latency: counts lag beats by one cycle, errors flag the cycle after the cause; backpressure: none, streams only observed.
module yolo_upsamp_seq
    import yolo_upsamp_pkg::*;
#(
    parameter int DIM_W   = 8,
    parameter int CB_W    = 8,
    parameter int CNT_W   = 26,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [CB_W-1:0]  cfg_chan_beats,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    output logic             k_ap_start,
    input  logic             k_ap_ready,
    input  logic             k_ap_done,
    input  logic             in_tvalid,
    input  logic             in_tready,
    input  logic             out_tvalid,
    input  logic             out_tready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] in_count,
    output logic [CNT_W-1:0] out_count
);

    typedef struct packed {
        logic [DIM_W-1:0] width;
        logic [DIM_W-1:0] height;
        logic [CB_W-1:0]  chan_beats;
    } cfg_t;

    state_t           state, state_nxt;
    cfg_t             cfg;
    logic [2:0]       code_nxt;
    logic [CNT_W-1:0] exp_in, exp_out, vol, in_nxt, out_nxt;
    logic             in_beat, out_beat, cnt_en, cfg_ok, take_cfg;
    logic             overrun, counts_match, wd_expired;
    logic [2:0]       wd_cause;

    assign in_beat  = in_tvalid & in_tready;
    assign out_beat = out_tvalid & out_tready;
    assign cnt_en   = (state == START) || (state == RUN);
    assign cfg_ok   = (|cfg_width) && (|cfg_height) && (|cfg_chan_beats);
    assign take_cfg = ((state == IDLE) || (state == ERR)) && cfg_start && cfg_ok;

    // Counts including this cycle's beats, so ap_done and overrun see the full total.
    assign in_nxt       = in_count + CNT_W'(in_beat);
    assign out_nxt      = out_count + CNT_W'(out_beat);
    assign overrun      = (in_nxt > exp_in) || (out_nxt > exp_out);
    assign counts_match = (in_nxt == exp_in) && (out_nxt == exp_out);
    assign vol          = CNT_W'(cfg.width) * CNT_W'(cfg.height) * CNT_W'(cfg.chan_beats);

    yolo_upsamp_wdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wdog (
        .clk        (ap_clk),
        .rst        (ap_rst),
        .en         (cnt_en),
        .beat       (in_beat | out_beat),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .expired    (wd_expired),
        .cause      (wd_cause)
    );

    always_comb begin
        state_nxt = state;
        code_nxt  = err_code;
        case (state)
            IDLE, ERR: begin
                if (cfg_start) begin
                    if (cfg_ok) begin
                        state_nxt = CALC;
                        code_nxt  = ERR_NONE;
                    end else begin
                        state_nxt = ERR;
                        code_nxt  = ERR_CFG;
                    end
                end
            end
            CALC: begin
                if (cfg_abort) begin
                    state_nxt = ERR;
                    code_nxt  = ERR_ABORT;
                end else begin
                    state_nxt = START;
                end
            end
            START, RUN: begin
                if (cfg_abort) begin
                    state_nxt = ERR;
                    code_nxt  = ERR_ABORT;
                end else if ((state == RUN) && k_ap_done) begin
                    state_nxt = counts_match ? DONE : ERR;
                    code_nxt  = counts_match ? err_code : ERR_MISMATCH;
                end else if (overrun) begin
                    state_nxt = ERR;
                    code_nxt  = ERR_OVERRUN;
                end else if (wd_expired) begin
                    state_nxt = ERR;
                    code_nxt  = wd_cause;
                end else if ((state == START) && k_ap_ready) begin
                    state_nxt = RUN;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= IDLE;
            cfg       <= '0;
            exp_in    <= '0;
            exp_out   <= '0;
            in_count  <= '0;
            out_count <= '0;
            err_code  <= ERR_NONE;
        end else begin
            state    <= state_nxt;
            err_code <= code_nxt;
            if (take_cfg) begin
                cfg       <= '{width: cfg_width, height: cfg_height, chan_beats: cfg_chan_beats};
                in_count  <= '0;
                out_count <= '0;
            end else if (cnt_en) begin
                in_count  <= in_nxt;
                out_count <= out_nxt;
            end
            if (state == CALC) begin
                exp_in  <= vol;
                exp_out <= vol << 2;
            end
        end
    end

    assign k_ap_start = (state == START);
    assign busy       = (state == CALC) || (state == START) || (state == RUN);
    assign done       = (state == DONE);
    assign error      = (state == ERR);

endmodule

// File: tb/tb_yolo_upsamp_seq.sv
// Bench for yolo_upsamp_seq: run-level reference model compared every cycle, plus directed literal checks.
module tb_yolo_upsamp_seq;

    localparam int DIM_W   = 8;
    localparam int CB_W    = 8;
    localparam int CNT_W   = 26;
    localparam int TIMEOUT = 4096;
    localparam int TO_W    = 13;

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic [DIM_W-1:0] cfg_width, cfg_height;
    logic [CB_W-1:0]  cfg_chan_beats;
    logic             cfg_start, cfg_abort;
    logic             k_ap_start, k_ap_ready, k_ap_done;
    logic             in_tvalid, in_tready, out_tvalid, out_tready;
    logic             busy, done, error;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] in_count, out_count;

    always #5 ap_clk = ~ap_clk;

    yolo_upsamp_seq #(
        .DIM_W(DIM_W), .CB_W(CB_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_chan_beats(cfg_chan_beats),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready), .k_ap_done(k_ap_done),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .in_count(in_count), .out_count(out_count)
    );

    int tests = 0;
    int fails = 0;
    int done_pulses = 0;
    int kstart_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Run-level reference model: tracks the run phase and beat totals from the
    // control rules directly, updated on each rising edge from the inputs just sampled.
    int m_in, m_out, m_exp, m_quiet, m_code;
    bit m_warm, m_launch, m_run, m_done, m_error;

    task automatic m_fail(input int code);
        m_warm   = 1'b0;
        m_launch = 1'b0;
        m_run    = 1'b0;
        m_error  = 1'b1;
        m_code   = code;
    endtask

    always @(posedge ap_clk) begin : model
        int ib, ob, ni, no, q;
        ib = (in_tvalid && in_tready) ? 1 : 0;
        ob = (out_tvalid && out_tready) ? 1 : 0;
        if (ap_rst) begin
            m_in = 0; m_out = 0; m_exp = 0; m_quiet = 0; m_code = 0;
            m_warm = 0; m_launch = 0; m_run = 0; m_done = 0; m_error = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_warm) begin
            m_warm = 0;
            if (cfg_abort) m_fail(7);
            else begin
                m_launch = 1;
                m_quiet  = 0;
            end
        end else if (m_launch || m_run) begin
            ni = m_in + ib;
            no = m_out + ob;
            q  = (ib + ob > 0) ? 0 : m_quiet + 1;
            m_in = ni; m_out = no; m_quiet = q;
            if (cfg_abort) m_fail(7);
            else if (m_run && k_ap_done) begin
                if (ni == m_exp && no == 4 * m_exp) begin
                    m_run  = 0;
                    m_done = 1;
                end else m_fail(5);
            end else if (ni > m_exp || no > 4 * m_exp) m_fail(4);
            else if (q >= TIMEOUT)
                m_fail((in_tready && !in_tvalid) ? 2 : ((out_tvalid && !out_tready) ? 3 : 6));
            else if (m_launch && k_ap_ready) begin
                m_launch = 0;
                m_run    = 1;
            end
        end else if (cfg_start) begin
            if (cfg_width != 0 && cfg_height != 0 && cfg_chan_beats != 0) begin
                m_error = 0; m_code = 0; m_in = 0; m_out = 0;
                m_exp  = int'(cfg_width) * int'(cfg_height) * int'(cfg_chan_beats);
                m_warm = 1;
            end else begin
                m_error = 1;
                m_code  = 1;
            end
        end
    end

    // Cycle compare, away from the active edge.
    initial begin
        forever begin
            @(negedge ap_clk);
            check("busy", busy, m_warm || m_launch || m_run);
            check("k_ap_start", k_ap_start, m_launch);
            check("done", done, m_done);
            check("error", error, m_error);
            check("err_code", err_code, m_code);
            check("in_count", in_count, m_in);
            check("out_count", out_count, m_out);
            if (done === 1'b1) done_pulses++;
            if (k_ap_start === 1'b1) kstart_cycles++;
        end
    end

    // Kernel stand-in: raises ap_ready for one cycle after seeing ap_start for 3 cycles.
    initial begin
        int kcnt;
        kcnt = 0;
        k_ap_ready = 1'b0;
        forever begin
            @(posedge ap_clk);
            #1;
            k_ap_ready = k_ap_start && (kcnt == 3);
            kcnt = k_ap_start ? kcnt + 1 : 0;
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_start = 0; cfg_abort = 0; k_ap_done = 0;
        in_tvalid = 0; in_tready = 0; out_tvalid = 0; out_tready = 0;
    endtask

    task automatic start_run(input int w, input int h, input int cb);
        cfg_width      = DIM_W'(w);
        cfg_height     = DIM_W'(h);
        cfg_chan_beats = CB_W'(cb);
        cfg_start      = 1;
        step();
        cfg_start      = 0;
    endtask

    task automatic wait_run(input string name);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (n < 20) begin
            if (k_ap_start) seen = 1;
            else if (seen && busy) break;
            step();
            n++;
        end
        check(name, n < 20, 1);
    endtask

    task automatic drive(input int nin, input int nout, input bit done_last);
        int len;
        len = (nin > nout) ? nin : nout;
        for (int c = 0; c < len; c++) begin
            in_tvalid  = (c < nin);
            in_tready  = (c < nin);
            out_tvalid = (c < nout);
            out_tready = (c < nout);
            k_ap_done  = done_last && (c == len - 1);
            step();
        end
        idle_inputs();
    endtask

    task automatic stall_run(input string name, input bit itv, input bit itr, input bit otv,
                             input bit otr, input int code);
        int n, guard;
        bit counting;
        start_run(2, 2, 1);
        in_tvalid = itv; in_tready = itr; out_tvalid = otv; out_tready = otr;
        n = 0; guard = 0; counting = 0;
        while (!error && guard < TIMEOUT + 50) begin
            if (k_ap_start) counting = 1;
            if (counting) n++;
            step();
            guard++;
        end
        idle_inputs();
        check({name, "_cycles"}, n, TIMEOUT);
        check({name, "_code"}, err_code, code);
    endtask

    initial begin
        idle_inputs();
        cfg_width = 0; cfg_height = 0; cfg_chan_beats = 0;
        ap_rst = 1;
        step();
        step();
        check("rst_outputs", {busy, k_ap_start, done, error, err_code, in_count, out_count}, 0);
        ap_rst = 0;
        step();

        // Full 13x13x16 run, ap_done coincident with the final out beat.
        kstart_cycles = 0; done_pulses = 0;
        start_run(13, 13, 16);
        wait_run("run1_reach_run");
        drive(2704, 10816, 1);
        check("run1_done", done, 1);
        check("run1_in", in_count, 2704);
        check("run1_out", out_count, 10816);
        check("run1_error", error, 0);
        step();
        check("run1_busy", busy, 0);
        check("run1_pulses", done_pulses, 1);
        check("run1_kstart", kstart_cycles, 4);

        // One out beat short at ap_done.
        start_run(13, 13, 16);
        wait_run("run2_reach_run");
        drive(2704, 10815, 0);
        k_ap_done = 1;
        step();
        k_ap_done = 0;
        check("mismatch_error", error, 1);
        check("mismatch_code", err_code, 5);
        check("mismatch_busy", busy, 0);

        stall_run("starve", 0, 1, 0, 0, 2);
        stall_run("bkpr", 0, 0, 1, 0, 3);

        // Overrun: second in beat on a 1-beat volume.
        start_run(1, 1, 1);
        wait_run("ovr_reach_run");
        in_tvalid = 1; in_tready = 1;
        step();
        check("ovr_first_ok", error, 0);
        step();
        idle_inputs();
        check("ovr_error", error, 1);
        check("ovr_code", err_code, 4);
        check("ovr_in", in_count, 2);

        // Zero width never reaches the kernel.
        kstart_cycles = 0;
        start_run(0, 13, 16);
        check("cfg_error", error, 1);
        check("cfg_code", err_code, 1);
        step(); step(); step();
        check("cfg_no_kstart", kstart_cycles, 0);
        check("cfg_busy", busy, 0);

        // Reset in the middle of a run, then a clean restart.
        start_run(13, 13, 16);
        wait_run("rst_reach_run");
        drive(100, 400, 0);
        ap_rst = 1;
        step();
        ap_rst = 0;
        check("midrst_outputs", {busy, k_ap_start, done, error, err_code, in_count, out_count}, 0);
        done_pulses = 0;
        start_run(1, 1, 1);
        wait_run("rst2_reach_run");
        drive(1, 4, 1);
        check("restart_done", done, 1);
        check("restart_out", out_count, 4);

        // Abort wins over a same-cycle ap_done.
        step();
        done_pulses = 0;
        start_run(1, 1, 1);
        wait_run("abort_reach_run");
        drive(1, 4, 0);
        k_ap_done = 1;
        cfg_abort = 1;
        step();
        idle_inputs();
        check("abort_code", err_code, 7);
        check("abort_error", error, 1);
        step();
        check("abort_no_done", done_pulses, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
